// File: rtl/mem_bus_initiator.sv
// mem_bus_initiator
//   CPU-side initiator for the word-addressed synchronous memory bus. Takes one
//   byte/halfword/word load or store from the core per ready/valid handshake.
//   Loads are extracted from the addressed lane and extended. Sub-word stores
//   are performed as read-modify-write of the containing word.
//
// Parameters
//   BIG_ENDIAN    0: byte k lives at bits [8k+7:8k], k = addr[1:0]
//                 1: lane index is addr[1:0] ^ 2'b11
//
// Ports
//   clk           system clock, all state changes on posedge
//   rst           synchronous active-low reset
//   cpu_req       request present
//   cpu_we        1 = store, 0 = load
//   cpu_size      00 byte, 01 halfword, 10 word, 11 illegal
//   cpu_sext      load sign-extend (1) or zero-extend (0)
//   cpu_addr      byte address
//   cpu_wdata     store data, right-aligned for sub-word stores
//   cpu_ready     high only in IDLE; request taken when cpu_req & cpu_ready
//   cpu_valid     one-cycle completion pulse
//   cpu_err       misaligned/illegal flag, qualified by cpu_valid
//   cpu_rdata     load result, held between successful loads
//   mem_addr      word address (latched cpu_addr[31:2])
//   mem_data_in   write word to memory
//   mem_wr_en     memory write strobe
//   mem_data_out  memory read data, one cycle after address
module mem_bus_initiator #(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_size,
  input  logic        cpu_sext,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ready,
  output logic        cpu_valid,
  output logic        cpu_err,
  output logic [31:0] cpu_rdata,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_data_in,
  output logic        mem_wr_en,
  input  logic [31:0] mem_data_out
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_CAP,
    WR,
    RMW_ADDR,
    RMW_CAP,
    RMW_WR,
    RESP
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  state_t      state;
  logic        accept;
  logic        misaligned;

  // Request fields needed after acceptance (word address lives in mem_addr).
  logic [1:0]  req_off;
  logic [1:0]  req_size;
  logic        req_sext;
  logic [31:0] req_wdata;

  logic [1:0]  byte_lane;
  logic        half_hi;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] load_data;
  logic [31:0] merged;

  assign cpu_ready = (state == IDLE);
  assign accept    = cpu_req & cpu_ready;

  assign misaligned = (cpu_size == 2'b11) ||
                      ((cpu_size == SIZE_HALF) && cpu_addr[0]) ||
                      ((cpu_size == SIZE_WORD) && (cpu_addr[1:0] != 2'b00));

  assign byte_lane = req_off ^ {2{BIG_ENDIAN}};
  assign half_hi   = req_off[1] ^ BIG_ENDIAN;

  // Lane extraction and extension of the returned word for loads.
  // NOTE: every signal assigned in always_comb gets a value on every path
  // (defaults first or a full case); otherwise a latch is inferred.
  always_comb begin
    sel_byte = mem_data_out[{byte_lane, 3'b000} +: 8];
    sel_half = half_hi ? mem_data_out[31:16] : mem_data_out[15:0];
    case (req_size)
      SIZE_BYTE: load_data = {{24{req_sext & sel_byte[7]}}, sel_byte};
      SIZE_HALF: load_data = {{16{req_sext & sel_half[15]}}, sel_half};
      default:   load_data = mem_data_out;
    endcase
  end

  // Read-modify-write merge: the old word with the target lane(s) replaced.
  always_comb begin
    merged = mem_data_out;
    if (req_size == SIZE_BYTE)
      merged[{byte_lane, 3'b000} +: 8] = req_wdata[7:0];
    else if (half_hi)
      merged[31:16] = req_wdata[15:0];
    else
      merged[15:0] = req_wdata[15:0];
  end

  // NOTE: pure datapath latches are only read in states reached after a
  // fresh acceptance, so they carry no reset; only control and visible
  // outputs are reset below.
  always_ff @(posedge clk) begin
    if (accept) begin
      req_off   <= cpu_addr[1:0];
      req_size  <= cpu_size;
      req_sext  <= cpu_sext;
      req_wdata <= cpu_wdata;
    end
  end

  // Control FSM with registered outputs. mem_wr_en and cpu_valid default low
  // each cycle and are raised only on the transition into the state that owns
  // them, so each is a single-cycle pulse.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      cpu_valid   <= 1'b0;
      cpu_err     <= 1'b0;
      cpu_rdata   <= '0;
      mem_addr    <= '0;
      mem_data_in <= '0;
      mem_wr_en   <= 1'b0;
    end else begin
      cpu_valid <= 1'b0;
      mem_wr_en <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req) begin
            if (misaligned) begin
              // No bus activity: respond with the error flag next cycle.
              cpu_err   <= 1'b1;
              cpu_valid <= 1'b1;
              state     <= RESP;
            end else begin
              cpu_err  <= 1'b0;
              mem_addr <= cpu_addr[31:2];
              if (!cpu_we) begin
                state <= RD_ADDR;
              end else if (cpu_size == SIZE_WORD) begin
                mem_data_in <= cpu_wdata;
                mem_wr_en   <= 1'b1;
                state       <= WR;
              end else begin
                state <= RMW_ADDR;
              end
            end
          end
        end
        RD_ADDR:  state <= RD_CAP;
        RD_CAP: begin
          cpu_rdata <= load_data;
          cpu_valid <= 1'b1;
          state     <= RESP;
        end
        WR: begin
          cpu_valid <= 1'b1;
          state     <= RESP;
        end
        RMW_ADDR: state <= RMW_CAP;
        RMW_CAP: begin
          mem_data_in <= merged;
          mem_wr_en   <= 1'b1;
          state       <= RMW_WR;
        end
        RMW_WR: begin
          cpu_valid <= 1'b1;
          state     <= RESP;
        end
        RESP:     state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_initiator.sv
// Self-checking bench for mem_bus_initiator: directed requests push their
// hand-computed responses into a scoreboard queue; a monitor pops and compares
// whenever cpu_valid is seen.
module tb_mem_bus_initiator;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req;
  logic        cpu_we;
  logic [1:0]  cpu_size;
  logic        cpu_sext;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_ready;
  logic        cpu_valid;
  logic        cpu_err;
  logic [31:0] cpu_rdata;
  logic [29:0] mem_addr;
  logic [31:0] mem_data_in;
  logic        mem_wr_en;
  logic [31:0] mem_data_out;

  always #5 clk = ~clk;

  mem_bus_initiator #(.BIG_ENDIAN(1'b0)) dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_req      (cpu_req),
    .cpu_we       (cpu_we),
    .cpu_size     (cpu_size),
    .cpu_sext     (cpu_sext),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_ready    (cpu_ready),
    .cpu_valid    (cpu_valid),
    .cpu_err      (cpu_err),
    .cpu_rdata    (cpu_rdata),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_wr_en    (mem_wr_en),
    .mem_data_out (mem_data_out)
  );

  // Synchronous memory model: write on strobe, read data registered.
  logic [31:0] mem [16];
  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_addr[3:0]] <= mem_data_in;
    mem_data_out <= mem[mem_addr[3:0]];
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          wr;
    logic [31:0] wdata;
  } exp_t;

  exp_t sb[$];

  task automatic push(input logic [31:0] rdata, input logic err, input int lat,
                      input int wr, input logic [31:0] wdata);
    exp_t e;
    e.rdata = rdata; e.err = err; e.lat = lat; e.wr = wr; e.wdata = wdata;
    sb.push_back(e);
  endtask

  // Monitor: cycle count, acceptance edges, write pulses, response compare.
  int          cyc = 0;
  int          acc_edge = 0;
  int          acc_edges[$];
  int          wr_txn = 0;
  int          wr_total = 0;
  logic [31:0] last_wdata = '0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst) begin
      if (mem_wr_en) begin
        wr_txn++;
        wr_total++;
        last_wdata = mem_data_in;
      end
      if (cpu_req && cpu_ready) begin
        acc_edge = cyc + 1;
        acc_edges.push_back(acc_edge);
        wr_txn = 0;
      end
      if (cpu_valid) begin
        check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          check("rdata", cpu_rdata, e.rdata);
          check("err", 32'(cpu_err), 32'(e.err));
          check("latency", 32'(cyc - acc_edge + 1), 32'(e.lat));
          check("wr_pulses", 32'(wr_txn), 32'(e.wr));
          if (e.wr != 0) check("wr_data", last_wdata, e.wdata);
        end
      end
    end
  end

  // Present a request, hold it until n acceptances, then wait for the
  // scoreboard to drain.
  task automatic issue(input logic we, input logic [1:0] size, input logic sext,
                       input logic [31:0] addr, input logic [31:0] wdata, input int n);
    int acc = 0;
    int waited = 0;
    cpu_we = we; cpu_size = size; cpu_sext = sext; cpu_addr = addr; cpu_wdata = wdata;
    cpu_req = 1'b1;
    while (acc < n && waited < 40) begin
      @(negedge clk);
      waited++;
      if (cpu_ready) acc++;
    end
    check("accept_in_time", 32'(acc), 32'(n));
    @(posedge clk);
    #1 cpu_req = 1'b0;
    waited = 0;
    while (sb.size() != 0 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    check("response_in_time", 32'(sb.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int base_wr;
    int gap;
    int waited;
    rst = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_size = 2'b00; cpu_sext = 1'b0;
    cpu_addr = '0; cpu_wdata = '0;
    for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_valid", 32'(cpu_valid), 32'd0);
    check("rst_err", 32'(cpu_err), 32'd0);
    check("rst_rdata", cpu_rdata, 32'h0);
    check("rst_mem_addr", 32'(mem_addr), 32'h0);
    check("rst_mem_data_in", mem_data_in, 32'h0);
    check("rst_wr_en", 32'(mem_wr_en), 32'd0);
    check("rst_ready", 32'(cpu_ready), 32'd1);
    @(posedge clk);
    #1;

    // Word load from mem[3].
    mem[3] <= 32'h00430820;
    mem[1] <= 32'h20028085;
    #1;
    push(32'h00430820, 1'b0, 3, 0, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 32'h0000_000C, 32'h0, 1);
    check("load_mem_addr", 32'(mem_addr), 32'd3);

    // Byte and halfword loads from mem[1] = 20028085.
    push(32'hFFFFFF80, 1'b0, 3, 0, 32'h0);
    issue(1'b0, 2'b00, 1'b1, 32'h0000_0005, 32'h0, 1);
    push(32'h00000085, 1'b0, 3, 0, 32'h0);
    issue(1'b0, 2'b00, 1'b0, 32'h0000_0004, 32'h0, 1);
    push(32'hFFFF8085, 1'b0, 3, 0, 32'h0);
    issue(1'b0, 2'b01, 1'b1, 32'h0000_0004, 32'h0, 1);
    push(32'h00002002, 1'b0, 3, 0, 32'h0);
    issue(1'b0, 2'b01, 1'b1, 32'h0000_0006, 32'h0, 1);

    // Byte store AA to 0x06 via read-modify-write.
    mem[1] <= 32'h20020005;
    #1;
    push(32'h00002002, 1'b0, 4, 1, 32'h20AA0005);
    issue(1'b1, 2'b00, 1'b0, 32'h0000_0006, 32'h0000_00AA, 1);
    check("rmw_mem1", mem[1], 32'h20AA0005);

    // Word store to mem[2].
    push(32'h00002002, 1'b0, 2, 1, 32'hDEADBEEF);
    issue(1'b1, 2'b10, 1'b0, 32'h0000_0008, 32'hDEADBEEF, 1);
    check("word_store_mem2", mem[2], 32'hDEADBEEF);

    // Misaligned halfword load and word store.
    push(32'h00002002, 1'b1, 1, 0, 32'h0);
    issue(1'b0, 2'b01, 1'b1, 32'h0000_0003, 32'h0, 1);
    push(32'h00002002, 1'b1, 1, 0, 32'h0);
    issue(1'b1, 2'b10, 1'b0, 32'h0000_0002, 32'h12345678, 1);
    check("err_store_mem0", mem[0], 32'h0);
    // Illegal size code.
    push(32'h00002002, 1'b1, 1, 0, 32'h0);
    issue(1'b0, 2'b11, 1'b0, 32'h0000_0000, 32'h0, 1);

    // Back-to-back loads with cpu_req held high.
    acc_edges.delete();
    push(32'hDEADBEEF, 1'b0, 3, 0, 32'h0);
    push(32'hDEADBEEF, 1'b0, 3, 0, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0008, 32'h0, 2);
    gap = (acc_edges.size() >= 2) ? acc_edges[1] - acc_edges[0] : -1;
    check("b2b_accept_gap", 32'(gap), 32'd4);

    // Reset during RMW_CAP of a halfword store: the write must be dropped.
    base_wr = wr_total;
    cpu_we = 1'b1; cpu_size = 2'b01; cpu_sext = 1'b0;
    cpu_addr = 32'h0000_000A; cpu_wdata = 32'h0000_1234;
    cpu_req = 1'b1;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!cpu_ready && waited < 40);
    check("rst_txn_accept", 32'(cpu_ready), 32'd1);
    @(posedge clk);            // E0 -> RMW_ADDR
    #1 cpu_req = 1'b0;
    @(posedge clk);            // E1 -> RMW_CAP
    #1 rst = 1'b0;
    @(posedge clk);            // reset sampled during RMW_CAP
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(cpu_ready), 32'd1);
    check("post_rst_rdata", cpu_rdata, 32'h0);
    repeat (6) @(negedge clk);
    check("rst_no_write", 32'(wr_total - base_wr), 32'd0);
    check("rst_mem2_intact", mem[2], 32'hDEADBEEF);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Hard stop if stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule

// File: doc/mem_bus_initiator.md
Name: mem_bus_initiator

Overview:
- CPU-side initiator for the word-addressed synchronous memory bus: 30-bit word address, 32-bit write data, write enable, registered read data one cycle after address.
- Accepts single byte/halfword/word load and store requests from the core over a ready/valid handshake and sequences the memory accesses.
- Sub-word stores are done as read-modify-write; sub-word loads are extracted and extended.
- Sits between the core's load/store/fetch logic and the memory in the master top level.

Parameters:
- BIG_ENDIAN, 0: byte-lane order. 0 = byte k at bits [8k+7:8k], k = addr[1:0]. 1 = lane index is addr[1:0] XOR 2'b11.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-low reset.
- cpu_req  in  1  request present.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- cpu_sext  in  1  load sign-extend when 1, zero-extend when 0.
- cpu_addr  in  32  byte address.
- cpu_wdata  in  32  store data, right-aligned for sub-word.
- cpu_ready  out  1  request accepted on an edge where cpu_req & cpu_ready.
- cpu_valid  out  1  one-cycle completion pulse.
- cpu_err  out  1  misaligned/illegal flag; meaningful only with cpu_valid.
- cpu_rdata  out  32  load result.
- mem_addr  out  30  word address, equal to latched cpu_addr[31:2].
- mem_data_in  out  32  write word to memory.
- mem_wr_en  out  1  memory write strobe.
- mem_data_out  in  32  memory read data, valid the cycle after address with mem_wr_en=0.

Behaviour:
- Reset (rst=0 at posedge):
  - State goes to IDLE.
  - cpu_valid=0, cpu_err=0, cpu_rdata=0, mem_addr=0, mem_data_in=0, mem_wr_en=0.
  - Any in-flight access is dropped: no cpu_valid and no further writes.
- States: IDLE, RD_ADDR, RD_CAP, WR, RMW_ADDR, RMW_CAP, RMW_WR, RESP.
- cpu_ready=1 only in IDLE.
- cpu_req outside IDLE is ignored, not queued.
- On acceptance (edge E0), latch addr, size, we, sext and wdata, then check alignment:
  - Illegal: size 11, half with addr[0]=1, or word with addr[1:0]!=0.
  - Illegal requests go to RESP with cpu_err=1. No memory access, no mem_wr_en. Latency 1 (cpu_valid high in cycle after E0).
- Load: IDLE -> RD_ADDR -> RD_CAP -> RESP.
  - In RD_CAP the selected lane of mem_data_out is extended per sext and registered into cpu_rdata.
  - cpu_valid in the 3rd cycle after E0.
- Word store: IDLE -> WR -> RESP.
  - WR drives mem_wr_en=1 for exactly one cycle with mem_data_in=wdata.
  - cpu_valid in the 2nd cycle after E0.
- Sub-word store: IDLE -> RMW_ADDR -> RMW_CAP -> RMW_WR -> RESP.
  - RMW_CAP registers the merge: mem_data_out with the target lane(s) replaced by wdata[7:0] or wdata[15:0].
  - RMW_WR writes the merged word with one mem_wr_en pulse.
  - cpu_valid in the 4th cycle after E0.
- RESP: cpu_valid=1 for one cycle, then IDLE. Next acceptance is possible in the cycle after RESP.
- mem_wr_en is 0 in every state except WR and RMW_WR.
- mem_addr holds its last value in IDLE. mem_data_in holds its last value.
- cpu_rdata:
  - Updated only on successful loads; held otherwise.
  - Unchanged on stores and errors.
- cpu_err=0 on every non-error response.
- Halfword lane: addr[1] selects upper/lower half, inverted when BIG_ENDIAN=1.

Test Plan:
- Reset, then a word load: mem[3]=32'h00430820, load word addr 0x0C -> mem_addr=3, mem_wr_en never 1, cpu_valid 3 cycles after accept, cpu_rdata=32'h00430820, cpu_err=0.
- Byte loads from mem[1]=32'h20028085, addr 0x05 (BIG_ENDIAN=0):
  - sext=1 -> cpu_rdata=32'hFFFFFF80.
  - Load byte addr 0x04 with sext=0 -> 32'h00000085.
- Byte store 8'hAA to addr 0x06 with mem[1]=32'h20020005 -> exactly one mem_wr_en pulse, mem_data_in=32'h20AA0005, cpu_valid 4 cycles after accept.
- Misaligned requests:
  - Halfword load addr 0x03 -> cpu_valid+cpu_err 1 cycle after accept, no mem_wr_en, cpu_rdata unchanged.
  - Word store addr 0x02 -> same, memory untouched.
- cpu_req held high across back-to-back loads -> second acceptance only in the cycle after first RESP; cpu_ready=0 throughout first transaction.
- rst driven low during RMW_CAP of a halfword store -> mem_wr_en stays 0, no cpu_valid, cpu_ready=1 the cycle after rst returns high; memory word unchanged.
